// File: rtl/aes_decrypt_sequencer.sv
// Sequences the iterative AES-128 inverse cipher around an owned 128-bit state register.
// Latency: 67 edges for NR=10 (load, 9 x {ISR,ISB,ARK,IMC x4}, ISR,ISB,ARK); done on edge 66 after accept.
// No backpressure: start is a level request taken only in IDLE; done is held until start drops.
module aes_decrypt_sequencer #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [127:0]          msg_en,
  input  logic [128*(NR+1)-1:0] key_schedule,
  output logic [127:0]          state_q,
  input  logic [127:0]          isr_in,
  input  logic [127:0]          isb_in,
  output logic [1:0]            imc_col_sel,
  input  logic [31:0]           imc_col_in,
  output logic [127:0]          msg_de,
  output logic                  busy,
  output logic                  done
);

  localparam int KW = 128 * (NR + 1);
  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] ROUND_FIRST = RW'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISR,
    S_ISB,
    S_ARK,
    S_IMC,
    S_DONE
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [127:0]    state_d;
  logic [127:0]    msg_de_q, msg_de_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      col_q, col_d;
  logic [RW-1:0]   round_q, round_d;

  // Round keys unpacked so that rk[0] is the cipher key held at the MSBs of the schedule.
  logic [127:0]    rk [NR+1];
  logic [127:0]    rk_cur;
  logic [127:0]    state_imc;

  for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
    assign rk[gi] = key_schedule[KW-1-128*gi -: 128];
  end

  assign rk_cur      = rk[round_q];
  assign imc_col_sel = col_q;
  assign msg_de      = msg_de_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Splice the single InvMixColumns result into the column currently being processed.
  always_comb begin
    state_imc = state_q;
    case (col_q)
      2'd0:    state_imc[127:96] = imc_col_in;
      2'd1:    state_imc[95:64]  = imc_col_in;
      2'd2:    state_imc[63:32]  = imc_col_in;
      default: state_imc[31:0]   = imc_col_in;
    endcase
  end

  // Next-state and datapath-register update for each step of the inverse cipher.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    msg_de_d = msg_de_q;
    busy_d   = busy_q;
    done_d   = done_q;
    col_d    = col_q;
    round_d  = round_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          // Initial AddRoundKey with the last round key folds into the load.
          state_d = msg_en ^ rk[NR];
          round_d = ROUND_FIRST;
          busy_d  = 1'b1;
          fsm_d   = S_ISR;
        end
      end
      S_ISR: begin
        state_d = isr_in;
        fsm_d   = S_ISB;
      end
      S_ISB: begin
        state_d = isb_in;
        fsm_d   = S_ARK;
      end
      S_ARK: begin
        state_d = state_q ^ rk_cur;
        if (round_q != '0) begin
          col_d = 2'd0;
          fsm_d = S_IMC;
        end else begin
          // Final round has no InvMixColumns; the result goes straight out.
          msg_de_d = state_q ^ rk_cur;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          fsm_d    = S_DONE;
        end
      end
      S_IMC: begin
        state_d = state_imc;
        col_d   = col_q + 2'd1;
        if (col_q == 2'd3) begin
          round_d = round_q - RW'(1);
          fsm_d   = S_ISR;
        end
      end
      S_DONE: begin
        // Require start to fall before another run can be accepted.
        if (!start) begin
          done_d = 1'b0;
          fsm_d  = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // State, result and status registers; reset discards any run in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= S_IDLE;
      state_q  <= '0;
      msg_de_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      col_q    <= 2'd0;
      round_q  <= ROUND_FIRST;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      msg_de_q <= msg_de_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      col_q    <= col_d;
      round_q  <= round_d;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer: supplies the inverse-cipher datapath units and key expansion.
// Latency: checks done on edge 66 after acceptance with FIPS-197 / SP800-38A plaintexts.
// Backpressure: start is held, pulsed and toggled to exercise the level handshake.
module tb_aes_decrypt_sequencer;

  localparam int NR = 10;
  localparam int KW = 128 * (NR + 1);
  localparam int LAT = 66;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [127:0]  msg_en;
  logic [KW-1:0] key_schedule;
  logic [127:0]  state_q;
  logic [127:0]  isr_in;
  logic [127:0]  isb_in;
  logic [1:0]    imc_col_sel;
  logic [31:0]   imc_col_in;
  logic [127:0]  msg_de;
  logic          busy;
  logic          done;

  aes_decrypt_sequencer #(.NR(NR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .msg_en       (msg_en),
    .key_schedule (key_schedule),
    .state_q      (state_q),
    .isr_in       (isr_in),
    .isb_in       (isb_in),
    .imc_col_sel  (imc_col_sel),
    .imc_col_in   (imc_col_in),
    .msg_de       (msg_de),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GF(2^8) helpers and S-box tables
  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [KW-1:0] expand(input logic [127:0] key);
    logic [31:0]   w [4*(NR+1)];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [KW-1:0] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 4*(NR+1); i++) ks[KW-1-32*i -: 32] = w[i];
    return ks;
  endfunction

  // External combinational units: InvShiftRows, InvSubBytes, single-column InvMixColumns
  logic [31:0] mc_col;
  logic [7:0]  a0, a1, a2, a3;
  always_comb begin
    isr_in = '0;
    isb_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        isr_in[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
    for (int k = 0; k < 16; k++)
      isb_in[127-8*k -: 8] = inv_sbox[state_q[127-8*k -: 8]];
    mc_col = state_q[127-32*imc_col_sel -: 32];
    a0 = mc_col[31:24];
    a1 = mc_col[23:16];
    a2 = mc_col[15:8];
    a3 = mc_col[7:0];
    imc_col_in = {gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
                  gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
                  gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
                  gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
  end

  // Scoreboard and counters
  typedef struct packed {
    logic [127:0] pt;
    int           acc;
  } exp_t;

  exp_t sb_q [$];
  exp_t e_pop;
  exp_t e_push;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected result whenever done rises, and tallies busy / column activity.
  logic       done_prev = 1'b0;
  logic [1:0] col_prev  = 2'd0;
  int         busy_cnt  = 0;
  int         wrap_cnt  = 0;
  int         nz_cnt    = 0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        e_pop = sb_q.pop_front();
        chk("plaintext", msg_de, e_pop.pt);
        chk("latency", 128'(cyc - e_pop.acc), 128'(LAT));
      end
    end
    done_prev = done;
    if (busy) busy_cnt++;
    if (col_prev == 2'd3 && imc_col_sel == 2'd0) wrap_cnt++;
    if (imc_col_sel != 2'd0) nz_cnt++;
    col_prev = imc_col_sel;
  end

  // Stimulus
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2  = 128'h6bc1bee22e409f96e93d7e117393172a;

  int acc;
  int busy_base;
  int wrap_base;
  int nz_base;

  task automatic start_run(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    key_schedule = expand(key);
    msg_en       = ct;
    start        = 1'b1;
    acc          = cyc + 1;
    e_push.pt    = pt;
    e_push.acc   = cyc + 1;
    sb_q.push_back(e_push);
    busy_base    = busy_cnt;
    wrap_base    = wrap_cnt;
    nz_base      = nz_cnt;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles expected done=1", name, n);
    end
  endtask

  task automatic wait_rel(input int k);
    while (cyc < acc + k) @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    msg_en       = '0;
    key_schedule = '0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      logic [7:0] s;
      b = ginv(8'(i));
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      sbox[i]     = s;
      inv_sbox[s] = 8'(i);
    end

    repeat (2) @(negedge clk);
    chk("reset_state_q", state_q, '0);
    chk("reset_msg_de", msg_de, '0);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_col_sel", 128'(imc_col_sel), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Run 1: FIPS-197 C.1 with a one-cycle start pulse
    start_run(KEY1, CT1, PT1);
    @(negedge clk);
    start = 1'b0;
    wait_done("run1");
    chk("run1_busy_cycles", 128'(busy_cnt - busy_base), 128'(LAT));
    chk("run1_imc_wraps", 128'(wrap_cnt - wrap_base), 128'(NR - 1));
    chk("run1_imc_nonzero", 128'(nz_cnt - nz_base), 128'(3 * (NR - 1)));
    @(negedge clk);
    chk("run1_done_drop", 128'(done), 128'(0));

    // Run 2: start toggled while busy must not disturb the sequence
    start_run(KEY1, CT1, PT1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 10; k <= 20; k++) begin
      wait_rel(k);
      start = (k % 2 == 1);
    end
    start = 1'b0;
    wait_done("run2");
    chk("run2_busy_cycles", 128'(busy_cnt - busy_base), 128'(LAT));
    @(negedge clk);
    chk("run2_done_drop", 128'(done), 128'(0));

    // Run 3: second vector with start held for 100 cycles
    start_run(KEY2, CT2, PT2);
    wait_rel(LAT - 1);
    chk("run3_old_msg_de_held", msg_de, PT1);
    wait_done("run3");
    wait_rel(99);
    chk("run3_done_held", 128'(done), 128'(1));
    chk("run3_no_rerun_busy", 128'(busy), 128'(0));
    chk("run3_busy_cycles", 128'(busy_cnt - busy_base), 128'(LAT));
    start = 1'b0;
    @(negedge clk);
    chk("run3_done_drop", 128'(done), 128'(0));
    chk("run3_msg_de_kept", msg_de, PT2);

    // Run 4: reset mid-run, then a fresh run
    start_run(KEY1, CT1, PT1);
    @(negedge clk);
    start = 1'b0;
    wait_rel(30);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midreset_state_q", state_q, '0);
    chk("midreset_msg_de", msg_de, '0);
    chk("midreset_busy", 128'(busy), 128'(0));
    chk("midreset_done", 128'(done), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_run(KEY1, CT1, PT1);
    @(negedge clk);
    start = 1'b0;
    wait_done("run4");
    chk("run4_busy_cycles", 128'(busy_cnt - busy_base), 128'(LAT));
    repeat (2) @(negedge clk);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
